// File: rtl/axi_pkg.sv
// Shared definitions for the AXI SRAM responder: response codes, arbiter grant
// encoding and the word-index width helper.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_e;

  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/axi_sram_responder_if.sv
// AXI single-beat bus between an initiator (master) and the SRAM responder (slave).
interface axi_sram_responder_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/sram_sp.sv
// Single-port synchronous SRAM with per-byte write enables and a registered read port.
module sram_sp #(
  parameter int WORDS  = 1024,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 10
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [IDX_W-1:0]    addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   q
);

  logic [DATA_W-1:0] mem [WORDS];

  // q only updates on reads, so it holds the last read word across writes
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < DATA_W/8; b++) begin
          if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end else begin
        q <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/axi_sram_responder.sv
// AXI single-beat responder in front of a single-port SRAM.
// Optional macro AXI_RESP_WSTRB_EN: when defined, wstrb drives the SRAM byte enables.
module axi_sram_responder
  import axi_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int MEM_WORDS = 1024
) (
  input logic                 clk,
  input logic                 resetn,
  axi_sram_responder_if.slave bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = idx_width(MEM_WORDS);
  localparam int OFS_W  = $clog2(STRB_W);
  localparam int HI_LSB = OFS_W + IDX_W;

  logic              ready_en_reg;
  logic              aw_full_reg, w_full_reg, ar_full_reg;
  logic [ID_W-1:0]   aw_id_reg, ar_id_reg;
  logic [ADDR_W-1:0] aw_addr_reg, ar_addr_reg;
  logic [DATA_W-1:0] w_data_reg;
  logic              w_last_reg;
  grant_e            last_grant_reg, last_grant_next;
  logic              b_pend_reg, bvalid_reg;
  logic [ID_W-1:0]   bid_reg, rid_reg;
  logic [1:0]        bresp_reg, rresp_reg;
  logic              r_pend_reg, rvalid_reg, rlast_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic              aw_hs, w_hs, ar_hs;
  logic              aw_oor, ar_oor, wr_err;
  logic              wr_req, rd_req, wr_go, rd_go;
  logic [STRB_W-1:0] wr_be;
  logic [IDX_W-1:0]  sram_addr;
  logic [DATA_W-1:0] sram_q;

  assign bus.awready = ready_en_reg & ~aw_full_reg;
  assign bus.wready  = ready_en_reg & ~w_full_reg;
  assign bus.arready = ready_en_reg & ~ar_full_reg;
  assign bus.bvalid  = bvalid_reg;
  assign bus.bid     = bid_reg;
  assign bus.bresp   = bresp_reg;
  assign bus.rvalid  = rvalid_reg;
  assign bus.rid     = rid_reg;
  assign bus.rdata   = rdata_reg;
  assign bus.rresp   = rresp_reg;
  assign bus.rlast   = rlast_reg;

  assign aw_hs = bus.awvalid & bus.awready;
  assign w_hs  = bus.wvalid  & bus.wready;
  assign ar_hs = bus.arvalid & bus.arready;

  // Address bits above the word index select nothing: such accesses are errors
  assign aw_oor = (aw_addr_reg >> HI_LSB) != '0;
  assign ar_oor = (ar_addr_reg >> HI_LSB) != '0;
  assign wr_err = aw_oor | ~w_last_reg;

`ifdef AXI_RESP_WSTRB_EN
  logic [STRB_W-1:0] w_strb_reg;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   w_strb_reg <= '0;
    else if (w_hs) w_strb_reg <= bus.wstrb;
  end
  assign wr_be = w_strb_reg;
`else
  logic unused_wstrb;
  assign unused_wstrb = ^bus.wstrb;
  assign wr_be = '1;
`endif

  // Pending flags keep a second request out until the response stage drains
  assign wr_req = aw_full_reg & w_full_reg & ~bvalid_reg & ~b_pend_reg;
  assign rd_req = ar_full_reg & ~rvalid_reg & ~r_pend_reg;
  assign wr_go  = wr_req & (~rd_req | (last_grant_reg == GRANT_RD));
  assign rd_go  = rd_req & (~wr_req | (last_grant_reg == GRANT_WR));

  always_comb begin
    last_grant_next = last_grant_reg;
    if (wr_req && rd_req) last_grant_next = wr_go ? GRANT_WR : GRANT_RD;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) last_grant_reg <= GRANT_RD;
    else         last_grant_reg <= last_grant_next;
  end

  assign sram_addr = wr_go ? aw_addr_reg[OFS_W +: IDX_W] : ar_addr_reg[OFS_W +: IDX_W];

  sram_sp #(
    .WORDS  (MEM_WORDS),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_sram (
    .clk   (clk),
    .en    (wr_go | rd_go),
    .we    (wr_go),
    .be    (wr_err ? '0 : wr_be),
    .addr  (sram_addr),
    .wdata (w_data_reg),
    .q     (sram_q)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_en_reg <= 1'b0;
      aw_full_reg  <= 1'b0;
      aw_id_reg    <= '0;
      aw_addr_reg  <= '0;
      w_full_reg   <= 1'b0;
      w_data_reg   <= '0;
      w_last_reg   <= 1'b0;
      ar_full_reg  <= 1'b0;
      ar_id_reg    <= '0;
      ar_addr_reg  <= '0;
    end else begin
      ready_en_reg <= 1'b1;
      if (aw_hs) begin
        aw_full_reg <= 1'b1;
        aw_id_reg   <= bus.awid;
        aw_addr_reg <= bus.awaddr;
      end else if (wr_go) begin
        aw_full_reg <= 1'b0;
      end
      if (w_hs) begin
        w_full_reg <= 1'b1;
        w_data_reg <= bus.wdata;
        w_last_reg <= bus.wlast;
      end else if (wr_go) begin
        w_full_reg <= 1'b0;
      end
      if (ar_hs) begin
        ar_full_reg <= 1'b1;
        ar_id_reg   <= bus.arid;
        ar_addr_reg <= bus.araddr;
      end else if (rd_go) begin
        ar_full_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      b_pend_reg <= 1'b0;
      bvalid_reg <= 1'b0;
      bid_reg    <= '0;
      bresp_reg  <= RESP_OKAY;
    end else begin
      b_pend_reg <= wr_go;
      if (wr_go) begin
        bid_reg   <= aw_id_reg;
        bresp_reg <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end
      if (b_pend_reg)       bvalid_reg <= 1'b1;
      else if (bus.bready)  bvalid_reg <= 1'b0;
    end
  end

  // Read data is captured one edge after the SRAM read, giving a stable R beat
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pend_reg <= 1'b0;
      rvalid_reg <= 1'b0;
      rlast_reg  <= 1'b0;
      rid_reg    <= '0;
      rresp_reg  <= RESP_OKAY;
      rdata_reg  <= '0;
    end else begin
      r_pend_reg <= rd_go;
      if (rd_go) begin
        rid_reg   <= ar_id_reg;
        rresp_reg <= ar_oor ? RESP_SLVERR : RESP_OKAY;
      end
      if (r_pend_reg) begin
        rvalid_reg <= 1'b1;
        rlast_reg  <= 1'b1;
        rdata_reg  <= (rresp_reg == RESP_SLVERR) ? '0 : sram_q;
      end else if (bus.rready) begin
        rvalid_reg <= 1'b0;
        rlast_reg  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed scoreboard bench for axi_sram_responder; honours AXI_RESP_WSTRB_EN in its model.
`timescale 1ns/1ps
module tb_axi_sram_responder;
  import axi_pkg::*;

  localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32, MEM_WORDS = 1024;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_sram_responder_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi_sram_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MEM_WORDS(MEM_WORDS)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; } r_exp_t;

  b_exp_t      b_q[$];
  r_exp_t      r_q[$];
  logic [31:0] model [logic [31:0]];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives optional write (W may lead AW by w_lead cycles) and optional read;
  // hs returns the cycle of the last handshake edge.
  task automatic issue(input bit wr, input logic [3:0] wid, input logic [31:0] waddr,
                       input logic [31:0] wdat, input logic [3:0] strb, input bit last,
                       input int w_lead, input bit rd, input logic [3:0] rid,
                       input logic [31:0] raddr, output int hs);
    bit aw_done, w_done, ar_done, aw_ok, w_ok, ar_ok;
    int k;
    b_exp_t be;
    r_exp_t re;
    logic [31:0] merged;
    aw_done = !wr; w_done = !wr; ar_done = !rd; k = 0;
    if (wr) begin
      be.id   = wid;
      be.resp = (waddr >= 32'h1000 || !last) ? RESP_SLVERR : RESP_OKAY;
      if (be.resp == RESP_OKAY) begin
        merged = model.exists(waddr) ? model[waddr] : 32'h0;
`ifdef AXI_RESP_WSTRB_EN
        for (int b = 0; b < 4; b++) if (strb[b]) merged[b*8 +: 8] = wdat[b*8 +: 8];
`else
        merged = wdat;
`endif
        model[waddr] = merged;
      end
      b_q.push_back(be);
    end
    if (rd) begin
      re.id = rid;
      if (raddr >= 32'h1000) begin
        re.data = 32'h0; re.resp = RESP_SLVERR;
      end else begin
        re.data = model.exists(raddr) ? model[raddr] : 32'h0; re.resp = RESP_OKAY;
      end
      r_q.push_back(re);
    end
    while (!(aw_done && w_done && ar_done) && k < 30) begin
      bus.awvalid = !aw_done && (k >= w_lead); bus.awid = wid; bus.awaddr = waddr;
      bus.wvalid  = !w_done; bus.wdata = wdat; bus.wstrb = strb; bus.wlast = last;
      bus.arvalid = !ar_done; bus.arid = rid; bus.araddr = raddr;
      aw_ok = bus.awvalid && bus.awready;
      w_ok  = bus.wvalid && bus.wready;
      ar_ok = bus.arvalid && bus.arready;
      tick();
      if (aw_ok) aw_done = 1'b1;
      if (w_ok)  w_done  = 1'b1;
      if (ar_ok) ar_done = 1'b1;
      k++;
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    check("issue_accepted", {aw_done, w_done, ar_done}, 3'b111);
    hs = cyc;
  endtask

  task automatic wait_br(input bit want_b, input bit want_r, input int hold, input bit complete,
                         output int b_cyc, output int r_cyc);
    bit got_b, got_r, held_ok;
    int n;
    b_exp_t be;
    r_exp_t re;
    got_b = !want_b; got_r = !want_r; b_cyc = -1; r_cyc = -1; n = 0; held_ok = 1'b1;
    be.id = '0; be.resp = '0; re.id = '0; re.data = '0; re.resp = '0;
    bus.bready = 1'b0; bus.rready = 1'b0;
    while (!(got_b && got_r) && n < 40) begin
      if (!got_b && bus.bvalid) begin got_b = 1'b1; b_cyc = cyc; end
      if (!got_r && bus.rvalid) begin got_r = 1'b1; r_cyc = cyc; end
      if (!(got_b && got_r)) begin tick(); n++; end
    end
    check("resp_seen", {got_b, got_r}, 2'b11);
    if (want_b && b_q.size() > 0) begin
      be = b_q.pop_front();
      check("bid", bus.bid, be.id);
      check("bresp", bus.bresp, be.resp);
      $display("B  id=%0h resp=%0h at cycle %0d", bus.bid, bus.bresp, b_cyc);
    end
    if (want_r && r_q.size() > 0) begin
      re = r_q.pop_front();
      check("rid", bus.rid, re.id);
      check("rdata", bus.rdata, re.data);
      check("rresp", bus.rresp, re.resp);
      check("rlast", bus.rlast, 1'b1);
      $display("R  id=%0h data=%08h resp=%0h at cycle %0d", bus.rid, bus.rdata, bus.rresp, r_cyc);
    end
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        tick();
        if (want_b && !(bus.bvalid === 1'b1 && bus.bid === be.id && bus.bresp === be.resp)) held_ok = 1'b0;
        if (want_r && !(bus.rvalid === 1'b1 && bus.rdata === re.data)) held_ok = 1'b0;
      end
      check("resp_held", held_ok, 1'b1);
    end
    if (complete) begin
      bus.bready = want_b; bus.rready = want_r;
      tick();
      bus.bready = 1'b0; bus.rready = 1'b0;
      if (want_b) check("bvalid_clear", bus.bvalid, 1'b0);
      if (want_r) check("rvalid_clear", bus.rvalid, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, bc, rc;
    bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
    bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.rready = 0;
    resetn = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid,
                            bus.rlast, bus.bid, bus.bresp, bus.rid, bus.rdata, bus.rresp}, 64'h0);
    resetn = 1'b1;
    check("ready_before_edge", {bus.awready, bus.wready, bus.arready}, 3'b000);
    tick();
    check("ready_after_edge", {bus.awready, bus.wready, bus.arready}, 3'b111);

    // AW+W together, B held 6 cycles before bready
    issue(1, 4'h3, 32'h4, 32'habcdaaaa, 4'hf, 1, 0, 0, 4'h0, 32'h0, hs);
    wait_br(1, 0, 6, 1, bc, rc);
    check("t1_b_latency", bc, hs + 2);

    issue(0, 4'h0, 32'h0, 32'h0, 4'h0, 1, 0, 1, 4'h9, 32'h4, hs);
    wait_br(0, 1, 0, 1, bc, rc);
    check("t2_r_latency", rc, hs + 2);

    // W three cycles ahead of AW
    issue(1, 4'h1, 32'h8, 32'h11223344, 4'hf, 1, 3, 0, 4'h0, 32'h0, hs);
    wait_br(1, 0, 0, 1, bc, rc);
    check("t3_b_latency", bc, hs + 2);
    issue(0, 4'h0, 32'h0, 32'h0, 4'h0, 1, 0, 1, 4'h2, 32'h8, hs);
    wait_br(0, 1, 0, 1, bc, rc);

    // Partial strobe write
    issue(1, 4'h4, 32'h8, 32'h55667788, 4'b0011, 1, 0, 0, 4'h0, 32'h0, hs);
    wait_br(1, 0, 0, 1, bc, rc);
    issue(0, 4'h0, 32'h0, 32'h0, 4'h0, 1, 0, 1, 4'h5, 32'h8, hs);
    wait_br(0, 1, 0, 1, bc, rc);

    // Two write/read conflicts: write wins first, read wins second
    issue(1, 4'h5, 32'hc, 32'hdeadbeef, 4'hf, 1, 0, 1, 4'h6, 32'h8, hs);
    wait_br(1, 1, 0, 1, bc, rc);
    check("t5a_b_latency", bc, hs + 2);
    check("t5a_r_latency", rc, hs + 3);
    issue(1, 4'h7, 32'h10, 32'h0badf00d, 4'hf, 1, 0, 1, 4'h8, 32'hc, hs);
    wait_br(1, 1, 0, 1, bc, rc);
    check("t5b_r_latency", rc, hs + 2);
    check("t5b_b_latency", bc, hs + 3);

    // Out-of-range write must not alias onto word 0; wlast=0 write must be dropped
    issue(1, 4'ha, 32'h0, 32'h600dcafe, 4'hf, 1, 0, 0, 4'h0, 32'h0, hs);
    wait_br(1, 0, 0, 1, bc, rc);
    issue(1, 4'hb, 32'h1000, 32'h12345678, 4'hf, 1, 0, 0, 4'h0, 32'h0, hs);
    wait_br(1, 0, 0, 1, bc, rc);
    issue(0, 4'h0, 32'h0, 32'h0, 4'h0, 1, 0, 1, 4'hc, 32'h0, hs);
    wait_br(0, 1, 0, 1, bc, rc);
    issue(1, 4'hd, 32'h4, 32'hffffffff, 4'hf, 0, 0, 0, 4'h0, 32'h0, hs);
    wait_br(1, 0, 0, 1, bc, rc);
    issue(0, 4'h0, 32'h0, 32'h0, 4'h0, 1, 0, 1, 4'h1, 32'h4, hs);
    wait_br(0, 1, 0, 1, bc, rc);

    // Out-of-range read, then reset while R is pending
    issue(0, 4'h0, 32'h0, 32'h0, 4'h0, 1, 0, 1, 4'he, 32'h0001_0000, hs);
    wait_br(0, 1, 0, 0, bc, rc);
    check("t6_r_latency", rc, hs + 2);
    resetn = 1'b0;
    #1;
    check("t6_async_clear", {bus.rvalid, bus.rlast, bus.arready, bus.bvalid, bus.rresp}, 64'h0);
    tick();
    resetn = 1'b1;
    check("t6_ready_before_edge", {bus.awready, bus.wready, bus.arready}, 3'b000);
    tick();
    check("t6_ready_after_edge", {bus.awready, bus.wready, bus.arready}, 3'b111);
    issue(0, 4'h0, 32'h0, 32'h0, 4'h0, 1, 0, 1, 4'hf, 32'h4, hs);
    wait_br(0, 1, 0, 1, bc, rc);
    check("t6_post_reset_r_latency", rc, hs + 2);

    check("scoreboard_empty", b_q.size() + r_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
